fft16_iter: RTL and testbench
=============================

Name: fft16_iter

Overview:
- Consumes the packed 16-sample frame produced by the sample-buffer stage.
- Computes an in-place radix-2 decimation-in-time 16-point FFT using one shared butterfly unit, so resource use is one complex multiplier.
- Emits all 16 complex bins in parallel, with a one-cycle valid pulse.
- Sits between the sample buffer and the spectrum post-processing logic.

Parameters:
- W, 32, sample/bin word width, signed Q16.16
- N, 16, transform length (fixed; only 16 supported)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_valid_i  in  1  one-cycle pulse: x holds a new frame
- x  in  512  16 real samples; sample i at bits [32*i+31 : 32*i], signed Q16.16; imaginary input is implicitly 0
- y_re  out  512  real part of bin k at bits [32*k+31 : 32*k], signed Q16.16
- y_im  out  512  imaginary part of bin k, same packing as y_re
- data_valid_o  out  1  one-cycle pulse: y_re/y_im hold a new result
- busy  out  1  high while in COMPUTE or DONE
- overrun  out  1  one-cycle pulse: frame dropped

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. On rst:
  - state = IDLE
  - working array, y_re, y_im all zero
  - data_valid_o = 0, overrun = 0, busy = 0
  - rst mid-COMPUTE abandons the frame; no data_valid_o is produced for it.
- State machine: IDLE -> COMPUTE -> DONE -> IDLE.
- IDLE, data_valid_i = 1:
  - Load working array: re[bitrev4(i)] = x[i], im = 0.
  - stage = 0, bfly = 0, state = COMPUTE.
- COMPUTE: one butterfly per clock; 4 stages x 8 butterflies = 32 cycles.
  - For stage s, butterfly b:
    - h = 2^s
    - top = (b >> s) * 2h + (b & (h-1)), bot = top + h
    - twiddle index k = (b & (h-1)) * (8 >> s)
  - Butterfly arithmetic:
    - t = W16^k * X[bot], where W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16).
    - Each real product is 64-bit signed; keep bits [47:16] (floor truncation).
    - X[top] <= (X[top] + t) >>> 1; X[bot] <= (X[top] - t) >>> 1.
    - Sums use 33-bit intermediates, then arithmetic shift to 32 bits; no saturation.
    - Net result = DFT/16, natural order.
  - bfly wraps 7 -> 0 with stage+1. After stage 3 / bfly 7 completes, state = DONE.
- DONE (one cycle): y_re/y_im <= working array; data_valid_o = 1 for exactly the following cycle; state = IDLE.
- Timing:
  - Accept edge = edge T. data_valid_o is high in the cycle after edge T+33 (latency 34 edges).
  - Max throughput: one frame per 34 cycles.
  - A new frame may be accepted in the same cycle data_valid_o is high.
- y_re/y_im hold their value until the next DONE.
- Overrun: data_valid_i = 1 while state != IDLE drops the frame; overrun pulses 1 cycle; the current computation is unaffected.
- Twiddle ROM, Q16.16, k = 0..7:
  - cos: 65536, 60547, 46341, 25080, 0, -25080, -46341, -60547
  - sin: 0, 25080, 46341, 60547, 65536, 60547, 46341, 25080

Decomposition:
- Shared package (fft_pkg):
  - W, N
  - state encoding (IDLE/COMPUTE/DONE)
  - twiddle cos/sin constants
  - bitrev4 function
- One sub-module: fft_bfly, a combinational complex butterfly with scaling.
  - Inputs: a_re, a_im, b_re, b_im, w_re, w_im.
  - Outputs: top_re, top_im, bot_re, bot_im.
- The FSM, address generation and working array stay in fft16_iter.

Test Plan:
- Impulse: x[0] = 65536, others 0 -> after 34 cycles, data_valid_o = 1; every y_re = 4096 exactly; every y_im = 0.
- DC: all x = 65536 -> y_re[0] = 65536, y_im[0] = 0; all other bins within +/-4 LSB of 0.
- Tone: x[i] = round(65536 * cos(2*pi*i/16)) -> y_re[1] and y_re[15] = 32768 +/-4; all other bins and all y_im within +/-4.
- Overrun: second data_valid_i 10 cycles after the first -> overrun pulses 1 cycle; first result correct; only one data_valid_o.
- Reset mid-compute: rst asserted 15 cycles after accept -> all outputs 0, busy = 0; no data_valid_o; a frame accepted after reset completes normally.
- Back-to-back: second frame presented in the data_valid_o cycle -> accepted with no overrun; second result correct 34 cycles later.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the iterative 16-point FFT: sizes, FSM encoding,
// twiddle ROM and bit-reversal helper.
package fft_pkg;

   localparam int unsigned W = 32;
   localparam int unsigned N = 16;

   typedef enum logic [1:0] {
      StIdle,
      StCompute,
      StDone
   } state_e;

   // cos(2*pi*k/16) in Q16.16
   function automatic logic signed [W-1:0] tw_cos(input logic [2:0] k);
      logic signed [W-1:0] v;
      unique case (k)
         3'd0: v = 32'sd65536;
         3'd1: v = 32'sd60547;
         3'd2: v = 32'sd46341;
         3'd3: v = 32'sd25080;
         3'd4: v = 32'sd0;
         3'd5: v = -32'sd25080;
         3'd6: v = -32'sd46341;
         3'd7: v = -32'sd60547;
      endcase
      return v;
   endfunction

   // sin(2*pi*k/16) in Q16.16
   function automatic logic signed [W-1:0] tw_sin(input logic [2:0] k);
      logic signed [W-1:0] v;
      unique case (k)
         3'd0: v = 32'sd0;
         3'd1: v = 32'sd25080;
         3'd2: v = 32'sd46341;
         3'd3: v = 32'sd60547;
         3'd4: v = 32'sd65536;
         3'd5: v = 32'sd60547;
         3'd6: v = 32'sd46341;
         3'd7: v = 32'sd25080;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] bitrev4(input logic [3:0] i);
      return {i[0], i[1], i[2], i[3]};
   endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 DIT butterfly with a 1/2 scale on both outputs.
// t = w * b with each real product truncated to Q16.16 by keeping bits [47:16].
module fft_bfly
   import fft_pkg::*;
(
   input  logic signed [W-1:0] a_re,
   input  logic signed [W-1:0] a_im,
   input  logic signed [W-1:0] b_re,
   input  logic signed [W-1:0] b_im,
   input  logic signed [W-1:0] w_re,
   input  logic signed [W-1:0] w_im,
   output logic signed [W-1:0] top_re,
   output logic signed [W-1:0] top_im,
   output logic signed [W-1:0] bot_re,
   output logic signed [W-1:0] bot_im
);

   logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [W-1:0]   t_re, t_im;
   logic signed [W:0]     s_top_re, s_top_im, s_bot_re, s_bot_im;

   // Complex multiply, then 33-bit sum/difference halved back to 32 bits
   always_comb begin
      // Low 64 bits of a product are signedness-independent, so plain sign extension suffices
      p_rr = $signed({{W{w_re[W-1]}}, w_re}) * $signed({{W{b_re[W-1]}}, b_re});
      p_ii = $signed({{W{w_im[W-1]}}, w_im}) * $signed({{W{b_im[W-1]}}, b_im});
      p_ri = $signed({{W{w_re[W-1]}}, w_re}) * $signed({{W{b_im[W-1]}}, b_im});
      p_ir = $signed({{W{w_im[W-1]}}, w_im}) * $signed({{W{b_re[W-1]}}, b_re});
      t_re = p_rr[47:16] - p_ii[47:16];
      t_im = p_ri[47:16] + p_ir[47:16];
      s_top_re = {a_re[W-1], a_re} + {t_re[W-1], t_re};
      s_top_im = {a_im[W-1], a_im} + {t_im[W-1], t_im};
      s_bot_re = {a_re[W-1], a_re} - {t_re[W-1], t_re};
      s_bot_im = {a_im[W-1], a_im} - {t_im[W-1], t_im};
      top_re = s_top_re[W:1];
      top_im = s_top_im[W:1];
      bot_re = s_bot_re[W:1];
      bot_im = s_bot_im[W:1];
   end

endmodule

// File: rtl/fft16_iter.sv
// Iterative in-place 16-point radix-2 DIT FFT using one shared butterfly.
// Accept -> 32 butterfly cycles -> DONE copies to outputs; result is DFT/16.
module fft16_iter
   import fft_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           data_valid_i,
   input  logic [N*W-1:0] x,
   output logic [N*W-1:0] y_re,
   output logic [N*W-1:0] y_im,
   output logic           data_valid_o,
   output logic           busy,
   output logic           overrun
);

   state_e                state_q, state_d;
   logic [1:0]            stage_q, stage_d;
   logic [2:0]            bfly_q, bfly_d;
   logic signed [W-1:0]   re_q [N];
   logic signed [W-1:0]   re_d [N];
   logic signed [W-1:0]   im_q [N];
   logic signed [W-1:0]   im_d [N];
   logic [N*W-1:0]        y_re_q, y_re_d, y_im_q, y_im_d;
   logic                  dv_q, dv_d, ovr_q, ovr_d;

   logic [3:0]            h, bfly_ext, low, top_idx, bot_idx, tw_tmp;
   logic [2:0]            tw_k;
   logic signed [W-1:0]   w_re, w_im;
   logic signed [W-1:0]   bf_top_re, bf_top_im, bf_bot_re, bf_bot_im;

   // Butterfly operand addresses and twiddle index for the current stage/bfly
   always_comb begin
      h        = 4'd1 << stage_q;
      bfly_ext = {1'b0, bfly_q};
      low      = bfly_ext & (h - 4'd1);
      top_idx  = ((bfly_ext >> stage_q) << ({1'b0, stage_q} + 3'd1)) | low;
      bot_idx  = top_idx | h;
      tw_tmp   = low << (2'd3 - stage_q);
      tw_k     = tw_tmp[2:0];
      w_re     = tw_cos(tw_k);
      w_im     = -tw_sin(tw_k);
   end

   fft_bfly u_bfly (
      .a_re   (re_q[top_idx]),
      .a_im   (im_q[top_idx]),
      .b_re   (re_q[bot_idx]),
      .b_im   (im_q[bot_idx]),
      .w_re   (w_re),
      .w_im   (w_im),
      .top_re (bf_top_re),
      .top_im (bf_top_im),
      .bot_re (bf_bot_re),
      .bot_im (bf_bot_im)
   );

   // Next-state: frame load, butterfly write-back, result publish, overrun detect
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      bfly_d  = bfly_q;
      re_d    = re_q;
      im_d    = im_q;
      y_re_d  = y_re_q;
      y_im_d  = y_im_q;
      dv_d    = 1'b0;
      ovr_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (data_valid_i) begin
               for (int unsigned i = 0; i < N; i++) begin
                  re_d[bitrev4(4'(i))] = x[W*i +: W];
                  im_d[i]              = '0;
               end
               stage_d = 2'd0;
               bfly_d  = 3'd0;
               state_d = StCompute;
            end
         end
         StCompute: begin
            ovr_d         = data_valid_i;
            re_d[top_idx] = bf_top_re;
            im_d[top_idx] = bf_top_im;
            re_d[bot_idx] = bf_bot_re;
            im_d[bot_idx] = bf_bot_im;
            bfly_d        = bfly_q + 3'd1;
            if (bfly_q == 3'd7) begin
               stage_d = stage_q + 2'd1;
               if (stage_q == 2'd3) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            ovr_d = data_valid_i;
            for (int unsigned i = 0; i < N; i++) begin
               y_re_d[W*i +: W] = re_q[i];
               y_im_d[W*i +: W] = im_q[i];
            end
            dv_d    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         stage_q <= 2'd0;
         bfly_q  <= 3'd0;
         re_q    <= '{default: '0};
         im_q    <= '{default: '0};
         y_re_q  <= '0;
         y_im_q  <= '0;
         dv_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
         re_q    <= re_d;
         im_q    <= im_d;
         y_re_q  <= y_re_d;
         y_im_q  <= y_im_d;
         dv_q    <= dv_d;
         ovr_q   <= ovr_d;
      end
   end

   assign y_re         = y_re_q;
   assign y_im         = y_im_q;
   assign data_valid_o = dv_q;
   assign overrun      = ovr_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_fft16_iter.sv
// Self-checking bench for fft16_iter: directed cases plus random frames checked
// against a bit-accurate array FFT model and a floating-point DFT.
module tb_fft16_iter;

   logic         clk;
   logic         rst;
   logic         data_valid_i;
   logic [511:0] x;
   logic [511:0] y_re;
   logic [511:0] y_im;
   logic         data_valid_o;
   logic         busy;
   logic         overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int dv_count = 0;
   int ovr_count = 0;

   int tcos [8] = '{65536, 60547, 46341, 25080, 0, -25080, -46341, -60547};
   int tsin [8] = '{0, 25080, 46341, 60547, 65536, 60547, 46341, 25080};

   fft16_iter dut (
      .clk          (clk),
      .rst          (rst),
      .data_valid_i (data_valid_i),
      .x            (x),
      .y_re         (y_re),
      .y_im         (y_im),
      .data_valid_o (data_valid_o),
      .busy         (busy),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (data_valid_o) dv_count++;
      if (overrun) ovr_count++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint got, input longint exp,
                        input longint tol);
      longint d;
      n_checks++;
      d = got - exp;
      if (d < 0) d = -d;
      if (d <= tol) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint bin_re(input int k);
      logic signed [31:0] v;
      v = y_re[32*k +: 32];
      return longint'(v);
   endfunction

   function automatic longint bin_im(input int k);
      logic signed [31:0] v;
      v = y_im[32*k +: 32];
      return longint'(v);
   endfunction

   function automatic logic [511:0] pack(input int xs[16]);
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[32*i +: 32] = xs[i];
      return v;
   endfunction

   // Textbook in-place DIT FFT over arrays with Q16.16 floor-truncated products, /2 per stage
   task automatic fft_model(input int xs[16], output longint yr[16], output longint yi[16]);
      longint ar [16];
      longint ai [16];
      longint wr, wi, tr, ti, pr, pi, qr, qi;
      int r, k, p, q;
      for (int i = 0; i < 16; i++) begin
         r = ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
         ar[r] = xs[i];
         ai[r] = 0;
      end
      for (int len = 2; len <= 16; len = len * 2) begin
         for (int st = 0; st < 16; st = st + len) begin
            for (int j = 0; j < len / 2; j++) begin
               k  = j * (16 / len);
               wr = tcos[k];
               wi = -tsin[k];
               p  = st + j;
               q  = p + len / 2;
               tr = ((wr * ar[q]) >>> 16) - ((wi * ai[q]) >>> 16);
               ti = ((wr * ai[q]) >>> 16) + ((wi * ar[q]) >>> 16);
               pr = ar[p]; pi = ai[p];
               qr = pr - tr; qi = pi - ti;
               ar[p] = (pr + tr) >>> 1;
               ai[p] = (pi + ti) >>> 1;
               ar[q] = qr >>> 1;
               ai[q] = qi >>> 1;
            end
         end
      end
      yr = ar;
      yi = ai;
   endtask

   task automatic check_exact(input string tag, input int xs[16]);
      longint yr [16];
      longint yi [16];
      fft_model(xs, yr, yi);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("%s_re[%0d]", tag, k), bin_re(k), yr[k], 0);
         check($sformatf("%s_im[%0d]", tag, k), bin_im(k), yi[k], 0);
      end
   endtask

   // Ideal DFT/16 in real arithmetic
   task automatic check_float(input string tag, input int xs[16], input longint tol);
      real sr, si, ang;
      for (int k = 0; k < 16; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < 16; n++) begin
            ang = 2.0 * 3.14159265358979323846 * real'(k * n) / 16.0;
            sr  = sr + real'(xs[n]) * $cos(ang);
            si  = si - real'(xs[n]) * $sin(ang);
         end
         check($sformatf("%s_re[%0d]", tag, k), bin_re(k), longint'(sr / 16.0), tol);
         check($sformatf("%s_im[%0d]", tag, k), bin_im(k), longint'(si / 16.0), tol);
      end
   endtask

   task automatic send(input int xs[16]);
      x            = pack(xs);
      data_valid_i = 1'b1;
      step();
      data_valid_i = 1'b0;
   endtask

   // Wait (bounded) for data_valid_o; exp_lat counts steps after the caller's position
   task automatic wait_done(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      while (!data_valid_o && lat < 100) begin
         step();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat, 0);
   endtask

   task automatic rand_frame(output int xs[16]);
      for (int i = 0; i < 16; i++) xs[i] = int'($urandom_range(33554432, 0)) - 16777216;
   endtask

   int fa [16];
   int fb [16];
   int dv0, ovr0;

   initial begin
      rst          = 1'b1;
      data_valid_i = 1'b0;
      x            = '0;
      step();
      step();
      check("rst_busy", busy, 0, 0);
      check("rst_dv", data_valid_o, 0, 0);
      check("rst_ovr", overrun, 0, 0);
      check("rst_yre", |y_re, 0, 0);
      check("rst_yim", |y_im, 0, 0);
      rst = 1'b0;
      step();

      // Impulse: exact 4096 in every real bin
      foreach (fa[i]) fa[i] = 0;
      fa[0] = 65536;
      send(fa);
      check("imp_busy", busy, 1, 0);
      wait_done("imp", 33);
      check_float("imp", fa, 0);
      step();
      check("imp_dv_pulse", data_valid_o, 0, 0);
      check("imp_idle", busy, 0, 0);

      // DC
      foreach (fa[i]) fa[i] = 65536;
      send(fa);
      wait_done("dc", 33);
      check("dc_bin0", bin_re(0), 65536, 0);
      check_float("dc", fa, 4);

      // Cosine at bin 1
      foreach (fa[i]) fa[i] = int'(65536.0 * $cos(2.0 * 3.14159265358979323846 * real'(i) / 16.0));
      send(fa);
      wait_done("tone", 33);
      check("tone_bin1", bin_re(1), 32768, 4);
      check("tone_bin15", bin_re(15), 32768, 4);
      check_float("tone", fa, 4);
      check_exact("tone", fa);

      // Random frames against the bit-accurate model
      for (int r = 0; r < 6; r++) begin
         rand_frame(fa);
         send(fa);
         wait_done($sformatf("rnd%0d", r), 33);
         check_exact($sformatf("rnd%0d", r), fa);
      end

      // Overrun: second frame 10 cycles after accept is dropped
      step();
      dv0  = dv_count;
      ovr0 = ovr_count;
      rand_frame(fa);
      rand_frame(fb);
      send(fa);
      repeat (9) step();
      send(fb);
      check("ovr_pulse", overrun, 1, 0);
      step();
      check("ovr_pulse_end", overrun, 0, 0);
      wait_done("ovr", 22);
      check_exact("ovr", fa);
      repeat (40) step();
      check("ovr_dv_count", dv_count - dv0, 1, 0);
      check("ovr_ovr_count", ovr_count - ovr0, 1, 0);

      // Reset 15 cycles after accept abandons the frame
      rand_frame(fa);
      send(fa);
      repeat (14) step();
      dv0 = dv_count;
      rst = 1'b1;
      step();
      check("rmid_busy", busy, 0, 0);
      check("rmid_dv", data_valid_o, 0, 0);
      check("rmid_ovr", overrun, 0, 0);
      check("rmid_yre", |y_re, 0, 0);
      check("rmid_yim", |y_im, 0, 0);
      rst = 1'b0;
      repeat (40) step();
      check("rmid_no_dv", dv_count - dv0, 0, 0);
      rand_frame(fa);
      send(fa);
      wait_done("rpost", 33);
      check_exact("rpost", fa);

      // Back-to-back: next frame presented while data_valid_o is high
      step();
      ovr0 = ovr_count;
      rand_frame(fa);
      rand_frame(fb);
      send(fa);
      wait_done("b2b_a", 33);
      check_exact("b2b_a", fa);
      send(fb);
      check("b2b_no_ovr", overrun, 0, 0);
      check("b2b_busy", busy, 1, 0);
      wait_done("b2b_b", 33);
      check_exact("b2b_b", fb);
      step();
      check("b2b_ovr_count", ovr_count - ovr0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
